// File: rtl/line_follow_pkg.sv
// Shared types and helpers for the line-follow controller: FSM encoding,
// signed velocity type, slew step and duty-code mapping.
package line_follow_pkg;

  localparam int         VEL_W   = 7;
  localparam logic [5:0] NEUTRAL = 6'd32;

  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FORWARD = 3'd1,
    ST_TURN_L  = 3'd2,
    ST_TURN_R  = 3'd3,
    ST_STOP    = 3'd4,
    ST_SEARCH  = 3'd5
  } state_e;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_e;

  // Move one unit toward the target, hold when already there.
  function automatic vel_t slew_step(input vel_t cur, input vel_t tgt);
    if (cur < tgt) begin
      return cur + vel_t'(1);
    end else if (cur > tgt) begin
      return cur - vel_t'(1);
    end
    return cur;
  endfunction

  // |vel| <= 31 keeps the result in 1..63, so the low six bits never wrap.
  function automatic logic [5:0] to_duty(input vel_t vel, input logic mirror);
    vel_t centre;
    vel_t code;
    centre = vel_t'(NEUTRAL);
    code   = mirror ? (centre - vel) : (centre + vel);
    return code[5:0];
  endfunction

endpackage

// File: rtl/line_follow_sensor_debounce.sv
// Two-flop synchroniser followed by a tick-paced debouncer: a new sensor
// pattern is accepted only after DEBOUNCE consecutive identical tick samples.
module sensor_debounce #(
  parameter int WIDTH    = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int             CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: every state element uses <= so all flops sample pre-edge values;
  // blocking here would let sync_q see this cycle's meta_q and collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    cnt_next = '0;
    if (tick) begin
      if (sync_q == stable_q) begin
        cnt_d = '0;
      end else begin
        // A non-zero count means cand_q is a run still in progress.
        if ((sync_q == cand_q) && (cnt_q != '0)) begin
          cnt_next = cnt_q + CNT_W'(1);
        end else begin
          cnt_next = CNT_W'(1);
        end
        cand_d = sync_q;
        if (cnt_next >= CNT_MAX) begin
          stable_d = sync_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/line_follow_controller.sv
// Line-follow robot controller: tick divider, steering FSM, per-wheel slew
// limiting and registered duty codes (right wheel mirrored).
module line_follow_controller
  import line_follow_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int DEBOUNCE     = 4,
  parameter int TURN_TIMEOUT = 500,
  parameter int SEARCH_SPEED = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] sensors,
  input  logic [5:0] speed,
  output logic [5:0] wheel_l,
  output logic [5:0] wheel_r,
  output logic [2:0] state,
  output logic       tick
);

  localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int               TO_W      = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TURN_TIMEOUT - 1);
  localparam int               S_MAG     = (SEARCH_SPEED > 31) ? 31 : SEARCH_SPEED;
  localparam vel_t             SEARCH_V  = vel_t'(S_MAG);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  state_e            state_q, state_d;
  side_e             last_q, last_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  vel_t              vel_l_q, vel_l_d, vel_r_q, vel_r_d;
  logic [5:0]        wheel_l_q, wheel_l_d, wheel_r_q, wheel_r_d;
  vel_t              tgt_l, tgt_r, base_v;
  logic [1:0]        stable;
  logic              speed_lsb_unused;

  assign speed_lsb_unused = speed[0];
  assign base_v           = vel_t'({2'b00, speed[5:1]});
  assign tick             = (tick_cnt_q == TICK_LAST);

  sensor_debounce #(
    .WIDTH   (2),
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick),
    .raw    (sensors),
    .stable (stable)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      last_q     <= SIDE_L;
      to_cnt_q   <= '0;
      vel_l_q    <= '0;
      vel_r_q    <= '0;
      wheel_l_q  <= NEUTRAL;
      wheel_r_q  <= NEUTRAL;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      last_q     <= last_d;
      to_cnt_q   <= to_cnt_d;
      vel_l_q    <= vel_l_d;
      vel_r_q    <= vel_r_d;
      wheel_l_q  <= wheel_l_d;
      wheel_r_q  <= wheel_r_d;
    end
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Steering FSM; branch order is the transition priority.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    to_cnt_d = '0;
    if (tick) begin
      if (!enable) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_FORWARD;
      end else if (stable == 2'b11) begin
        state_d = ST_STOP;
      end else if (state_q == ST_STOP) begin
        if (stable == 2'b00) state_d = ST_FORWARD;
      end else if (state_q == ST_SEARCH) begin
        // The side that timed out is still on the sensors; only a change exits.
        if (stable == 2'b00) begin
          state_d = ST_FORWARD;
        end else if ((stable == 2'b10) && (last_q == SIDE_R)) begin
          state_d = ST_TURN_L;
          last_d  = SIDE_L;
        end else if ((stable == 2'b01) && (last_q == SIDE_L)) begin
          state_d = ST_TURN_R;
          last_d  = SIDE_R;
        end
      end else begin
        case (stable)
          2'b10: begin
            last_d = SIDE_L;
            if (state_q == ST_TURN_L) begin
              state_d = (to_cnt_q == TO_LAST) ? ST_SEARCH : ST_TURN_L;
            end else begin
              state_d = ST_TURN_L;
            end
          end
          2'b01: begin
            last_d = SIDE_R;
            if (state_q == ST_TURN_R) begin
              state_d = (to_cnt_q == TO_LAST) ? ST_SEARCH : ST_TURN_R;
            end else begin
              state_d = ST_TURN_R;
            end
          end
          default: state_d = ST_FORWARD;
        endcase
      end
      if (((state_d == ST_TURN_L) || (state_d == ST_TURN_R)) && (state_d == state_q)) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    case (state_q)
      ST_FORWARD: begin
        tgt_l = base_v;
        tgt_r = base_v;
      end
      ST_TURN_L: tgt_r = base_v;
      ST_TURN_R: tgt_l = base_v;
      ST_SEARCH: begin
        tgt_l = (last_q == SIDE_L) ? -SEARCH_V : SEARCH_V;
        tgt_r = (last_q == SIDE_L) ? SEARCH_V : -SEARCH_V;
      end
      default: ;
    endcase
  end

  // Duty codes are registered from the post-slew velocity on the same tick.
  always_comb begin
    vel_l_d   = vel_l_q;
    vel_r_d   = vel_r_q;
    wheel_l_d = wheel_l_q;
    wheel_r_d = wheel_r_q;
    if (tick) begin
      vel_l_d   = slew_step(vel_l_q, tgt_l);
      vel_r_d   = slew_step(vel_r_q, tgt_r);
      wheel_l_d = to_duty(vel_l_d, 1'b0);
      wheel_r_d = to_duty(vel_r_d, 1'b1);
    end
  end

  assign wheel_l = wheel_l_q;
  assign wheel_r = wheel_r_q;
  assign state   = state_q;

endmodule

// File: tb/tb_line_follow_controller.sv
// Directed bench for line_follow_controller with TICK_DIV=4, DEBOUNCE=2,
// TURN_TIMEOUT=8, SEARCH_SPEED=8; expected codes worked out by hand per tick.
module tb_line_follow_controller;

  localparam int TD = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable  = 1'b0;
  logic [1:0] sensors = 2'b00;
  logic [5:0] speed   = 6'd0;
  logic [5:0] wheel_l, wheel_r;
  logic [2:0] state;
  logic       tick;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  line_follow_controller #(
    .TICK_DIV    (TD),
    .DEBOUNCE    (2),
    .TURN_TIMEOUT(8),
    .SEARCH_SPEED(8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .sensors(sensors),
    .speed  (speed),
    .wheel_l(wheel_l),
    .wheel_r(wheel_r),
    .state  (state),
    .tick   (tick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int el, input int er, input int es);
    check({tag, "_wl"}, {2'b00, wheel_l}, el[7:0]);
    check({tag, "_wr"}, {2'b00, wheel_r}, er[7:0]);
    check({tag, "_st"}, {5'b0, state}, es[7:0]);
  endtask

  // Steps are aligned to the falling edge right after a tick update.
  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clock);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check_out("reset", 32, 32, 0);
    check("reset_tick", {7'b0, tick}, 8'd0);

    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (20) @(negedge clock);
      check_out("idle_hold", 32, 32, 0);
    end

    // Start: v = 40 >> 1 = 20.
    speed  = 6'd40;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check("tick_hi", {7'b0, tick}, 8'd1);
    @(negedge clock);
    check("tick_lo", {7'b0, tick}, 8'd0);
    check_out("fwd_t1", 32, 32, 1);
    ticks(1);
    check_out("fwd_t2", 33, 31, 1);
    ticks(18);
    check_out("fwd_t20", 51, 13, 1);
    ticks(1);
    check_out("fwd_t21", 52, 12, 1);
    ticks(4);
    check_out("fwd_hold", 52, 12, 1);

    // Left line: debounce 2 ticks, FSM on 3rd, ramp from 4th.
    sensors = 2'b10;
    ticks(2);
    check_out("turnl_debounce", 52, 12, 1);
    ticks(1);
    check_out("turnl_enter", 52, 12, 2);
    ticks(1);
    check_out("turnl_ramp", 51, 12, 2);
    ticks(6);
    check_out("turnl_t10", 45, 12, 2);
    ticks(1);
    check_out("search_enter", 44, 12, 5);
    ticks(20);
    check_out("search_spin", 24, 24, 5);

    sensors = 2'b00;
    ticks(2);
    check_out("search_hold", 24, 24, 5);
    ticks(1);
    check_out("search_exit", 24, 24, 1);
    ticks(29);
    check_out("fwd_again", 52, 12, 1);

    // One-tick glitch must not survive the debouncer.
    sensors = 2'b01;
    ticks(1);
    sensors = 2'b00;
    ticks(5);
    check_out("glitch", 52, 12, 1);

    sensors = 2'b11;
    ticks(2);
    check_out("stop_debounce", 52, 12, 1);
    ticks(1);
    check_out("stop_enter", 52, 12, 4);
    ticks(19);
    check_out("stop_ramp", 33, 31, 4);
    ticks(1);
    check_out("stop_settled", 32, 32, 4);

    sensors = 2'b00;
    ticks(3);
    check_out("stop_exit", 32, 32, 1);
    ticks(20);
    check_out("stop_refwd", 52, 12, 1);

    // Disable together with a sensor change: enable wins, ramp to stop.
    enable  = 1'b0;
    sensors = 2'b10;
    ticks(1);
    check_out("disable", 52, 12, 0);
    ticks(3);
    check_out("enable_wins", 49, 15, 0);
    ticks(4);
    check_out("ramp_mid", 45, 19, 0);

    reset_n = 1'b0;
    #1;
    check_out("reset_async", 32, 32, 0);
    check("reset_async_tick", {7'b0, tick}, 8'd0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
